// File: rtl/merge_pkt_scheduler.sv
// Tags every segment of an input beat with a per-pass packet number for the merge crossbar,
// splitting beats that carry more packets than output lanes over several back-pressured passes.
module merge_pkt_scheduler #(
    parameter int SEG_NUM_IN  = 64,
    parameter int PKT_NUM_OUT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEG_NUM_IN-1:0]   in_sop,
    input  logic [SEG_NUM_IN-1:0]   in_eop,
    input  logic [SEG_NUM_IN-1:0]   in_dval,
    output logic                    out_valid,
    output logic [SEG_NUM_IN-1:0]   out_sop,
    output logic [SEG_NUM_IN-1:0]   out_eop,
    output logic [SEG_NUM_IN-1:0]   out_dval,
    output logic [4*SEG_NUM_IN-1:0] out_packet_num,
    output logic [3:0]              out_pkt_cnt,
    output logic                    err_orphan,
    output logic                    err_sop_open
);

    localparam int RW = $clog2(SEG_NUM_IN) + 1;
    localparam int BW = RW + 1;
    localparam logic [BW-1:0] PKT = BW'(PKT_NUM_OUT);

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t          state_reg, state_next;
    logic [BW-1:0]   base_reg, base_next;
    logic            valid_reg, valid_next;
    logic            carry_open_reg;
    logic [RW-1:0]   tot_reg;
    logic            orphan_reg, sop_err_reg;
    logic [SEG_NUM_IN-1:0] sop_reg, eop_reg, dval_reg;
    logic [RW-1:0]   raw_reg [SEG_NUM_IN];

    logic [RW-1:0]   scan_raw [SEG_NUM_IN];
    logic [RW-1:0]   scan_cnt, scan_tot;
    logic            scan_open, scan_orphan, scan_sop_err;
    logic            accept, load, last_pass;

    // Raw packet index of the incoming beat, scanned from segment 0 upward.
    always_comb begin
        scan_cnt     = carry_open_reg ? RW'(1) : '0;
        scan_open    = carry_open_reg;
        scan_tot     = '0;
        scan_orphan  = 1'b0;
        scan_sop_err = 1'b0;
        for (int i = 0; i < SEG_NUM_IN; i++) begin
            scan_raw[i] = '0;
            if (in_dval[i]) begin
                if (in_sop[i]) begin
                    if (scan_open) scan_sop_err = 1'b1;
                    scan_cnt  = scan_cnt + RW'(1);
                    scan_open = 1'b1;
                end
                if (scan_open) begin
                    scan_raw[i] = scan_cnt;
                    scan_tot    = scan_cnt;
                    if (in_eop[i]) scan_open = 1'b0;
                end else begin
                    scan_orphan = 1'b1;
                end
            end
        end
    end

    // The last pass is the one whose lane window reaches the highest raw index.
    assign last_pass = (base_reg + PKT) >= BW'(tot_reg);
    assign in_ready  = (state_reg == IDLE) || last_pass;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_next = state_reg;
        base_next  = base_reg;
        valid_next = 1'b0;
        load       = 1'b0;
        if (state_reg == SPLIT && !last_pass) begin
            valid_next = 1'b1;
            base_next  = base_reg + PKT;
        end else if (accept) begin
            load       = 1'b1;
            valid_next = 1'b1;
            base_next  = '0;
            state_next = (BW'(scan_tot) > PKT) ? SPLIT : IDLE;
        end else begin
            base_next  = '0;
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            base_reg       <= '0;
            valid_reg      <= 1'b0;
            carry_open_reg <= 1'b0;
            tot_reg        <= '0;
            orphan_reg     <= 1'b0;
            sop_err_reg    <= 1'b0;
            sop_reg        <= '0;
            eop_reg        <= '0;
            dval_reg       <= '0;
            for (int i = 0; i < SEG_NUM_IN; i++) raw_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            base_reg  <= base_next;
            valid_reg <= valid_next;
            if (load) begin
                carry_open_reg <= scan_open;
                tot_reg        <= scan_tot;
                orphan_reg     <= scan_orphan;
                sop_err_reg    <= scan_sop_err;
                sop_reg        <= in_sop;
                eop_reg        <= in_eop;
                dval_reg       <= in_dval;
                for (int i = 0; i < SEG_NUM_IN; i++) raw_reg[i] <= scan_raw[i];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SEG_NUM_IN; gi++) begin : g_seg
            logic [BW-1:0] raw_ext;
            logic          hit;
            assign raw_ext = BW'(raw_reg[gi]);
            assign hit     = valid_reg && (raw_ext > base_reg) && (raw_ext <= base_reg + PKT);
            assign out_packet_num[4*gi +: 4] = hit ? 4'(raw_ext - base_reg) : 4'd0;
            assign out_sop[gi]  = hit && sop_reg[gi];
            assign out_eop[gi]  = hit && eop_reg[gi];
            assign out_dval[gi] = hit && dval_reg[gi];
        end
    endgenerate

    logic [BW-1:0] remaining;
    assign remaining    = BW'(tot_reg) - base_reg;
    assign out_valid    = valid_reg;
    assign out_pkt_cnt  = !valid_reg ? 4'd0 : (remaining > PKT) ? 4'(PKT) : 4'(remaining);
    // Error pulses belong to the first pass of a beat only.
    assign err_orphan   = valid_reg && (base_reg == '0) && orphan_reg;
    assign err_sop_open = valid_reg && (base_reg == '0) && sop_err_reg;

endmodule

// File: doc/merge_pkt_scheduler.md
Name: merge_pkt_scheduler

Overview:
- Per-beat packet-numbering scheduler placed directly in front of the segment merge crossbar.
- Scans the SEG_NUM_IN segment flags (sop/eop/dval) of each input beat and tags every segment with a packet number 1..PKT_NUM_OUT. Crossbar output lane i then collects every segment tagged i+1.
- Tracks packets that span beats.
- When a beat holds more packets than the crossbar has output lanes, splits that beat over several output passes and back-pressures the source.

Parameters:
- SEG_NUM_IN, 64, segments per beat (32-bit segments).
- PKT_NUM_OUT, 8, crossbar output lanes, i.e. maximum packets per output pass (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_sop  in  SEG_NUM_IN  per-segment start of packet.
- in_eop  in  SEG_NUM_IN  per-segment end of packet.
- in_dval  in  SEG_NUM_IN  per-segment data valid.
- out_valid  out  1  tagged pass valid (no backpressure from the crossbar).
- out_sop  out  SEG_NUM_IN  sop, masked to this pass.
- out_eop  out  SEG_NUM_IN  eop, masked to this pass.
- out_dval  out  SEG_NUM_IN  dval, masked to this pass.
- out_packet_num  out  4*SEG_NUM_IN  per-segment lane tag; 0 means not in this pass.
- out_pkt_cnt  out  4  number of packet tags used in this pass.
- err_orphan  out  1  one-cycle pulse: a dval segment lay outside any packet.
- err_sop_open  out  1  one-cycle pulse: sop arrived while a packet was open.

Behaviour:
- Reset state: all outputs 0; in_ready=1; carry_open=0; pass index p=0; state IDLE.
- Raw index (combinational, over the held beat, segment 0 first):
  - The running packet count starts at 1 if carry_open, else 0.
  - Each sop with dval increments the count; that segment gets raw = count.
  - Each segment after an sop, up to and including its eop, gets the same raw.
  - With carry_open, segments before the first sop get raw=1.
  - dval=0 segments get raw=0 and do not change the open/closed state.
  - A dval=1 segment with no packet open gets raw=0 and asserts err_orphan.
- sop while a packet is open: the previous packet is implicitly closed, a new packet starts, and err_sop_open asserts.
- sop and eop on the same segment: single-segment packet.
- Total packets T = max raw in the beat (0..SEG_NUM_IN). Passes needed N = ceil(T/PKT_NUM_OUT), minimum 1.
- Pass p emits:
  - out_packet_num = raw - p*PKT_NUM_OUT for raw in (p*PKT_NUM_OUT, (p+1)*PKT_NUM_OUT]; 0 otherwise.
  - out_sop, out_eop and out_dval are gated to segments with nonzero out_packet_num.
  - out_pkt_cnt = min(PKT_NUM_OUT, T - p*PKT_NUM_OUT).
- State machine:
  - IDLE: on accept, register the beat, compute raw.
    - N=1: emit next cycle, remain able to accept.
    - N>1: go to SPLIT with p=0; in_ready=0.
  - SPLIT: emit pass p each cycle, p++. After pass N-1 emits: in_ready returns to 1 in the same cycle, p=0, go to IDLE.
- Latency: 1 cycle from accept to first pass; full throughput when N=1.
- The err pulses accompany the first pass of the offending beat only.
- carry_open: updated at beat accept to "a packet is open after the last dval segment of the beat". Unchanged by in_valid=0 cycles.
- Raw-index arithmetic uses $clog2(SEG_NUM_IN)+1 bits; no wrap-around.
- rst mid-SPLIT: the remaining passes are discarded and the block returns to the reset state.

Test Plan:
1. Beat: sop seg0, eop seg3, dval 0..3, carry_open=0 → one pass; tags seg0-3 = 1, rest 0; out_pkt_cnt=1; in_ready stays 1.
2. Beat A: sop seg60, dval 60..63, no eop. Beat B: dval 0..1, eop seg1, sop seg2 / eop seg2 → B tags seg0-1 = 1, seg2 = 2; out_pkt_cnt=2.
3. Beat: 10 single-segment packets on seg0..9 → pass0 tags 1..8 on seg0..7 with out_pkt_cnt=8; pass1 tags seg8=1, seg9=2 with out_pkt_cnt=2; in_ready low for exactly 1 cycle.
4. Beat: 64 single-segment packets → 8 passes of 8 tags each; in_ready low 7 cycles; the next beat is accepted on the cycle of the last pass.
5. dval on seg5 with no open packet → err_orphan=1 for one cycle; seg5 tag=0. sop on seg2 and seg4, eop seg6 → err_sop_open=1; seg2-3 tag 1, seg4-6 tag 2.
6. Assert rst during pass 3 of the case-4 beat → all outputs 0 immediately; in_ready=1; the following beat with carry-dependent segments before its first sop tags them 0 with err_orphan.
